// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary-to-BCD converter (shift-and-add-3).
// Uses the same start/finished handshake as the upstream divider, so
// divider.out_finished can drive in_start directly.
//
// Ports:
//   in_clk        system clock, rising edge
//   in_rst        synchronous reset, active low
//   in_start      start request, honoured only in IDLE or DONE
//   in_num        unsigned binary operand, captured on the accepted start edge
//   out_bcd       packed BCD result, digit 0 (ones) in [3:0]
//   out_finished  result valid (DONE state)
//   out_busy      conversion in progress (ADD3 / SHIFT)
//   out_overflow  value did not fit in OUT_DIGITS, valid with out_finished
module bcd_converter #(
    parameter int IN_BITS    = 16,
    parameter int OUT_DIGITS = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_start,
    input  logic [IN_BITS-1:0]      in_num,
    output logic [4*OUT_DIGITS-1:0] out_bcd,
    output logic                    out_finished,
    output logic                    out_busy,
    output logic                    out_overflow
);

    localparam int BW = 4 * OUT_DIGITS;
    localparam int CW = $clog2(IN_BITS + 1);

    typedef enum logic [1:0] {IDLE, ADD3, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [IN_BITS-1:0] shreg;
    logic [BW-1:0]      scratch, scratch_adj;
    logic [CW-1:0]      cnt;
    logic               ovf;
    logic               accept;

    // Per-digit correction: every nibble >= 5 gets +3 (mod 16), all in parallel.
    for (genvar d = 0; d < OUT_DIGITS; d++) begin : g_adj
        assign scratch_adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ?
                                       scratch[4*d +: 4] + 4'd3 :
                                       scratch[4*d +: 4];
    end

    assign accept = in_start && (state == IDLE || state == DONE);

    always_ff @(posedge in_clk) begin
        if (!in_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        out_busy     = 1'b0;
        out_finished = 1'b0;
        case (state)
            IDLE:  if (in_start) state_nxt = ADD3;
            ADD3: begin
                out_busy  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                out_busy  = 1'b1;
                state_nxt = (cnt == CW'(1)) ? DONE : ADD3;
            end
            DONE: begin
                out_finished = 1'b1;
                if (in_start) state_nxt = ADD3;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            shreg        <= '0;
            scratch      <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_bcd      <= '0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            shreg   <= in_num;
            scratch <= '0;
            cnt     <= CW'(IN_BITS);
            ovf     <= 1'b0;
        end else if (state == ADD3) begin
            scratch <= scratch_adj;
        end else if (state == SHIFT) begin
            // {scratch, shreg} shifted left as one register; the bit falling
            // off the scratch MSB belongs to a digit we do not keep.
            shreg   <= {shreg[IN_BITS-2:0], 1'b0};
            scratch <= {scratch[BW-2:0], shreg[IN_BITS-1]};
            ovf     <= ovf | scratch[BW-1];
            cnt     <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                // Output registers change only on the edge that enters DONE.
                out_bcd      <= {scratch[BW-2:0], shreg[IN_BITS-1]};
                out_overflow <= ovf | scratch[BW-1];
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed testbench for bcd_converter: a 5-digit instance and a 4-digit
// instance share all inputs, so the 4-digit one covers the overflow cases.
module tb_bcd_converter;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_start = 1'b0;
    logic [15:0] in_num = '0;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic        fin5, busy5, ovf5, fin4, busy4, ovf4;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    always #5 in_clk = ~in_clk;

    bcd_converter #(.IN_BITS(16), .OUT_DIGITS(5)) dut5 (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_num(in_num),
        .out_bcd(bcd5), .out_finished(fin5), .out_busy(busy5), .out_overflow(ovf5)
    );

    bcd_converter #(.IN_BITS(16), .OUT_DIGITS(4)) dut4 (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_num(in_num),
        .out_bcd(bcd4), .out_finished(fin4), .out_busy(busy4), .out_overflow(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven and outputs sampled here.
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic start_pulse(input logic [15:0] num);
        in_num   = num;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("busy_after_start", {30'd0, busy5, fin5}, 32'h2);
    endtask

    // Call right after the start edge. Counts edges until out_finished
    // (bounded), checks out_bcd still holds prev mid-way, and optionally
    // pokes a start with another operand at cycle poke.
    task automatic wait_done(input logic [19:0] prev, input int poke, output int l);
        l = 0;
        while (!fin5 && l < 40) begin
            tick();
            l++;
            if (l == 16) chk("hold_prev", bcd5, prev);
            if (poke != 0 && l == poke) begin
                in_num   = 16'd4321;
                in_start = 1'b1;
            end
            if (poke != 0 && l == poke + 1) in_start = 1'b0;
        end
        chk("latency", l, 32);
        chk("busy_done", busy5, 1'b0);
    endtask

    initial begin
        // Reset state
        in_rst = 1'b0;
        tick();
        tick();
        chk("rst_bcd5", bcd5, 0);
        chk("rst_flags5", {fin5, busy5, ovf5}, 0);
        chk("rst_bcd4", bcd4, 0);
        in_rst = 1'b1;
        tick();
        chk("idle_flags", {fin5, busy5}, 0);

        // 500
        start_pulse(16'd500);
        wait_done(20'h00000, 0, lat);
        chk("bcd_500", bcd5, 20'h00500);
        chk("ovf_500", ovf5, 1'b0);
        chk("bcd4_500", bcd4, 16'h0500);

        // 65535: previous result held mid-way; 4-digit overflows
        start_pulse(16'd65535);
        wait_done(20'h00500, 0, lat);
        chk("bcd_65535", bcd5, 20'h65535);
        chk("ovf_65535", ovf5, 1'b0);
        chk("bcd4_65535", bcd4, 16'h5535);
        chk("ovf4_65535", ovf4, 1'b1);

        // 0 still takes full latency
        start_pulse(16'd0);
        wait_done(20'h65535, 0, lat);
        chk("bcd_0", bcd5, 20'h00000);
        chk("ovf4_0", ovf4, 1'b0);

        // Back-to-back: start held high, operand switches after capture
        in_num   = 16'd123;
        in_start = 1'b1;
        tick();
        in_num = 16'd9999;
        wait_done(20'h00000, 0, lat);
        chk("bcd_123", bcd5, 20'h00123);
        tick();
        in_start = 1'b0;
        chk("b2b_fin_one_cycle", {30'd0, fin5, busy5}, 32'h1);
        wait_done(20'h00123, 0, lat);
        chk("bcd_9999", bcd5, 20'h09999);
        chk("bcd4_9999", bcd4, 16'h9999);
        chk("ovf4_9999", ovf4, 1'b0);

        // Start during conversion is ignored
        start_pulse(16'd1234);
        wait_done(20'h09999, 10, lat);
        chk("bcd_ignore", bcd5, 20'h01234);

        // Reset mid-conversion
        start_pulse(16'd777);
        for (int i = 0; i < 15; i++) tick();
        in_rst = 1'b0;
        tick();
        chk("midrst_bcd", bcd5, 0);
        chk("midrst_flags", {fin5, busy5, ovf5}, 0);
        in_rst = 1'b1;
        tick();
        chk("midrst_idle", {fin5, busy5}, 0);
        start_pulse(16'd42);
        wait_done(20'h00000, 0, lat);
        chk("bcd_42", bcd5, 20'h00042);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
